// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - power-up reset sequencer with lock supervision and retry/fault handling
module rst_seq_ctrl #(
  parameter int N_STAGE   = 3,
  parameter int CNT_W     = 24,
  parameter int HOLD_CYC  = 1000,
  parameter int LOCK_TMO  = 100000,
  parameter int STAGE_DLY = 1000,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               lock_in,
  input  logic               sw_rst_req,
  output logic [N_STAGE-1:0] stage_rst,
  output logic               all_ready,
  output logic               fault,
  output logic [1:0]         retry_cnt,
  output logic [2:0]         state
);

  localparam int K_W = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(LOCK_TMO - 1);
  localparam logic [CNT_W-1:0] DLY_LAST   = CNT_W'(STAGE_DLY - 1);
  localparam logic [K_W-1:0]   K_LAST     = K_W'(N_STAGE - 1);
  localparam logic [1:0]       RETRY_LIM  = 2'(MAX_RETRY);
  localparam logic [N_STAGE-1:0] ALL_HELD = '1;

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [K_W-1:0]   k;
  logic             lock_meta;
  logic             lock_s;
  logic             retry_ev;

  assign state = st;

  // Two-flop resynchronizer for the asynchronous lock indicator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= lock_in;
      lock_s    <= lock_meta;
    end
  end

  // Retry condition: lock timeout while waiting, or lock loss once releasing/running
  always_comb begin
    retry_ev = 1'b0;
    case (st)
      S_WAIT_LOCK: retry_ev = !lock_s && (cnt == TMO_LAST);
      S_RELEASE:   retry_ev = !lock_s;
      S_RUN:       retry_ev = !lock_s;
      default:     retry_ev = 1'b0;
    endcase
  end

  // Sequencer FSM; soft restart outranks retry, retry outranks normal progression
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= S_HOLD;
      cnt       <= '0;
      k         <= '0;
      stage_rst <= ALL_HELD;
      all_ready <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 2'd0;
    end else if (sw_rst_req) begin
      st        <= S_HOLD;
      cnt       <= '0;
      k         <= '0;
      stage_rst <= ALL_HELD;
      all_ready <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 2'd0;
    end else if (retry_ev) begin
      cnt       <= '0;
      k         <= '0;
      stage_rst <= ALL_HELD;
      all_ready <= 1'b0;
      if (retry_cnt < RETRY_LIM) begin
        st        <= S_HOLD;
        retry_cnt <= retry_cnt + 2'd1;
      end else begin
        // Budget spent: park in FAULT with the retry count left as-is
        st    <= S_FAULT;
        fault <= 1'b1;
      end
    end else begin
      case (st)
        S_HOLD: begin
          stage_rst <= ALL_HELD;
          if (cnt == HOLD_LAST) begin
            st  <= S_WAIT_LOCK;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          stage_rst <= ALL_HELD;
          if (lock_s) begin
            st  <= S_RELEASE;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RELEASE: begin
          if (cnt == DLY_LAST) begin
            cnt <= '0;
            // Shifting left releases bit k and keeps every higher bit held,
            // so domains can only come out of reset in index order
            stage_rst <= stage_rst << 1;
            if (k == K_LAST) begin
              st        <= S_RUN;
              all_ready <= 1'b1;
              k         <= '0;
            end else begin
              k <= k + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RUN: begin
          stage_rst <= '0;
          all_ready <= 1'b1;
        end

        S_FAULT: begin
          // Lock activity is ignored here; only soft restart or reset leaves
          stage_rst <= ALL_HELD;
          fault     <= 1'b1;
          all_ready <= 1'b0;
        end

        default: begin
          st        <= S_HOLD;
          cnt       <= '0;
          k         <= '0;
          stage_rst <= ALL_HELD;
          all_ready <= 1'b0;
          fault     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - directed self-checking bench for rst_seq_ctrl
module tb_rst_seq_ctrl;

  logic       clk;
  logic       reset_n;
  logic       lock_in;
  logic       sw_rst_req;
  logic [2:0] stage_rst;
  logic       all_ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int errors;
  int checks;
  int cur_edge;

  rst_seq_ctrl #(
    .N_STAGE  (3),
    .CNT_W    (24),
    .HOLD_CYC (8),
    .LOCK_TMO (20),
    .STAGE_DLY(4),
    .MAX_RETRY(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .lock_in   (lock_in),
    .sw_rst_req(sw_rst_req),
    .stage_rst (stage_rst),
    .all_ready (all_ready),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (after edge %0d)", tag, got, exp, cur_edge);
    end
  endtask

  // Advance to 1 time unit after the given edge number
  task automatic run_to(input int e);
    while (cur_edge < e) begin
      @(posedge clk);
      cur_edge++;
    end
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n  = 1'b1;
    cur_edge = -1;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    cur_edge   = -1;
    reset_n    = 1'b0;
    lock_in    = 1'b1;
    sw_rst_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_stage", stage_rst, 3'b111);
    check("rst_ready", all_ready, 0);
    check("rst_fault", fault, 0);
    check("rst_retry", retry_cnt, 0);
    check("rst_state", state, 0);

    // Nominal bring-up
    release_reset();
    run_to(6);  check("nom_hold6", state, 0);
    run_to(7);  check("nom_wait7", state, 1);
    run_to(8);  check("nom_rel8", state, 2);
                check("nom_stage8", stage_rst, 3'b111);
    run_to(11); check("nom_stage11", stage_rst, 3'b111);
    run_to(12); check("nom_stage12", stage_rst, 3'b110);
    run_to(16); check("nom_stage16", stage_rst, 3'b100);
    run_to(19); check("nom_ready19", all_ready, 0);
    run_to(20); check("nom_stage20", stage_rst, 3'b000);
                check("nom_ready20", all_ready, 1);
                check("nom_state20", state, 3);

    // Lock loss in RUN: lock_in falls before edge 30
    run_to(29); lock_in = 1'b0;
    run_to(31); check("loss_state31", state, 3);
    run_to(32); check("loss_stage32", stage_rst, 3'b111);
                check("loss_ready32", all_ready, 0);
                check("loss_state32", state, 0);
                check("loss_retry32", retry_cnt, 1);
    lock_in = 1'b1;
    run_to(40); check("loss_wait40", state, 1);
    run_to(45); check("loss_stage45", stage_rst, 3'b110);
    run_to(53); check("loss_state53", state, 3);
                check("loss_ready53", all_ready, 1);
                check("loss_retry53", retry_cnt, 1);

    // Soft restart from RUN, then lock never arrives (edge 55 acts as edge 0)
    lock_in = 1'b0;
    sw_rst_req = 1'b1;
    run_to(54); check("sw_state54", state, 0);
                check("sw_retry54", retry_cnt, 0);
    sw_rst_req = 1'b0;
    run_to(81);  check("nolock_wait81", state, 1);
                 check("nolock_retry81", retry_cnt, 0);
    run_to(82);  check("nolock_state82", state, 0);
                 check("nolock_retry82", retry_cnt, 1);
    run_to(110); check("nolock_retry110", retry_cnt, 2);
                 check("nolock_state110", state, 0);
    run_to(137); check("nolock_wait137", state, 1);
                 check("nolock_fault137", fault, 0);
    run_to(138); check("nolock_state138", state, 4);
                 check("nolock_fault138", fault, 1);
                 check("nolock_retry138", retry_cnt, 2);
                 check("nolock_stage138", stage_rst, 3'b111);
                 check("nolock_ready138", all_ready, 0);
    lock_in = 1'b1;
    run_to(238); check("fault_state238", state, 4);
                 check("fault_fault238", fault, 1);
                 check("fault_stage238", stage_rst, 3'b111);

    // Soft restart from FAULT (edge 240 acts as edge 0)
    sw_rst_req = 1'b1;
    run_to(239); check("sr_state239", state, 0);
                 check("sr_fault239", fault, 0);
                 check("sr_retry239", retry_cnt, 0);
    sw_rst_req = 1'b0;
    run_to(247); check("sr_wait247", state, 1);
    run_to(252); check("sr_stage252", stage_rst, 3'b110);
    run_to(260); check("sr_state260", state, 3);
                 check("sr_ready260", all_ready, 1);

    // Simultaneous soft restart and WAIT_LOCK timeout with retry_cnt=1
    lock_in = 1'b0;
    run_to(263); check("sim_retry263", retry_cnt, 1);
                 check("sim_state263", state, 0);
    run_to(290); check("sim_state290", state, 1);
    sw_rst_req = 1'b1;
    run_to(291); check("sim_state291", state, 0);
                 check("sim_retry291", retry_cnt, 0);
                 check("sim_fault291", fault, 0);
    sw_rst_req = 1'b0;
    run_to(319); check("sim_state319", state, 0);
                 check("sim_retry319", retry_cnt, 1);
                 check("sim_fault319", fault, 0);

    // Asynchronous reset while stage_rst=110
    lock_in = 1'b1;
    run_to(332); check("ar_stage332", stage_rst, 3'b110);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_stage", stage_rst, 3'b111);
    check("ar_ready", all_ready, 0);
    check("ar_state", state, 0);
    check("ar_retry", retry_cnt, 0);
    repeat (2) @(posedge clk);
    release_reset();
    run_to(7);  check("ar_wait7", state, 1);
    run_to(12); check("ar_stage12", stage_rst, 3'b110);
    run_to(20); check("ar_state20", state, 3);
                check("ar_stage20", stage_rst, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
